keypad_scanner: RTL

Scans the calculator's 4-column × 5-row key matrix, debounces it and turns each clean key press into a single-cycle event for the operand register stage. Outputs are `newhex`/`hexcode`, `newop`/`opcode` and `eq`. These drive the register block's `newhex`, `hexcode`, `newop` and `eq` inputs directly; `opcode` goes to the arithmetic block. Exactly one event is produced per physical press, regardless of hold time or contact bounce.

---
 rtl/keypad_scanner_if.sv | 22 ++
 rtl/keypad_scanner.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner_if.sv
// Matrix and event bundle between the keypad scanner and the register/arithmetic blocks.
// master: scanner side (drives columns and events); slave: matrix/consumer side.
interface keypad_scanner_if;
    logic [4:0] row_n;
    logic [3:0] col_n;
    logic       newhex;
    logic [3:0] hexcode;
    logic       newop;
    logic [1:0] opcode;
    logic       eq;
    logic       keydown;

    modport master (
        input  row_n,
        output col_n, newhex, hexcode, newop, opcode, eq, keydown
    );

    modport slave (
        output row_n,
        input  col_n, newhex, hexcode, newop, opcode, eq, keydown
    );
endinterface

// File: rtl/keypad_scanner.sv
// 4x5 key matrix scanner: column scan, full-matrix snapshot, debounce FSM and
// one registered event pulse per accepted key press.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              clock,
    input  logic              reset,
    keypad_scanner_if.master  bus
);
    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (DEBOUNCE_SCANS > 0) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE   = CW'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {S_IDLE, S_ARMING, S_ACCEPT, S_HELD} state_t;

    logic [4:0]    r_row_meta;
    logic [4:0]    r_row_sync;
    logic [DW-1:0] r_dwell;
    logic [1:0]    r_col;
    logic [3:0]    r_col_n;
    logic [19:0]   r_snap;
    logic          r_snap_done;

    state_t        r_state, w_state_next;
    logic [CW-1:0] r_cnt, w_cnt_next;
    logic [4:0]    r_key, w_key_next;

    logic          r_newhex;
    logic [3:0]    r_hexcode;
    logic          r_newop;
    logic [1:0]    r_opcode;
    logic          r_eq;

    logic          w_last_dwell;
    logic          w_none;
    logic          w_single;
    logic [4:0]    w_idx;
    logic [CW-1:0] w_cnt_inc;

    assign w_last_dwell = (r_dwell == DWELL_LAST);
    assign w_cnt_inc    = r_cnt + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_row_meta <= '1;
            r_row_sync <= '1;
        end else begin
            r_row_meta <= bus.row_n;
            r_row_sync <= r_row_meta;
        end
    end

    // Column timing free-runs in every FSM state.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_dwell     <= '0;
            r_col       <= '0;
            r_col_n     <= 4'b1110;
            r_snap_done <= 1'b0;
        end else begin
            r_snap_done <= w_last_dwell && (r_col == 2'd3);
            if (w_last_dwell) begin
                r_dwell <= '0;
                r_col   <= r_col + 2'd1;
                r_col_n <= {r_col_n[2:0], r_col_n[3]};
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
        end
    end

    // Snapshot bit 4*r+c is set when row r reads low while column c is driven.
    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_row
            always_ff @(posedge clock) begin
                if (reset) begin
                    r_snap[4*gi +: 4] <= '0;
                end else if (w_last_dwell) begin
                    r_snap[4*gi + int'(r_col)] <= ~r_row_sync[gi];
                end
            end
        end
    endgenerate

    always_comb begin
        int ones;
        ones  = 0;
        w_idx = '0;
        for (int i = 0; i < 20; i++) begin
            if (r_snap[i]) begin
                ones  = ones + 1;
                w_idx = 5'(i);
            end
        end
        w_none   = (ones == 0);
        w_single = (ones == 1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_key   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_key   <= w_key_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_key_next   = r_key;
        case (r_state)
            S_IDLE: begin
                if (r_snap_done && w_single) begin
                    w_key_next   = w_idx;
                    w_cnt_next   = CW'(1);
                    w_state_next = (DEBOUNCE_SCANS <= 1) ? S_ACCEPT : S_ARMING;
                end
            end
            S_ARMING: begin
                if (r_snap_done) begin
                    if (w_single && (w_idx == r_key)) begin
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc == CNT_DONE) begin
                            w_state_next = S_ACCEPT;
                        end
                    end else if (w_single) begin
                        w_key_next = w_idx;
                        w_cnt_next = CW'(1);
                    end else begin
                        w_cnt_next   = '0;
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_ACCEPT: begin
                w_cnt_next   = '0;
                w_state_next = S_HELD;
            end
            S_HELD: begin
                if (r_snap_done) begin
                    if (!w_none) begin
                        w_cnt_next = '0;
                    end else if (w_cnt_inc == CNT_DONE) begin
                        w_cnt_next   = '0;
                        w_state_next = S_IDLE;
                    end else begin
                        w_cnt_next = w_cnt_inc;
                    end
                end
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Pulses are registered out of ACCEPT, so they line up with the first HELD cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_newhex  <= 1'b0;
            r_hexcode <= '0;
            r_newop   <= 1'b0;
            r_opcode  <= '0;
            r_eq      <= 1'b0;
        end else begin
            r_newhex <= (r_state == S_ACCEPT) && !r_key[4];
            r_newop  <= (r_state == S_ACCEPT) && r_key[4] && (r_key[1:0] != 2'd3);
            r_eq     <= (r_state == S_ACCEPT) && r_key[4] && (r_key[1:0] == 2'd3);
            if ((r_state == S_ACCEPT) && !r_key[4]) begin
                r_hexcode <= r_key[3:0];
            end
            if ((r_state == S_ACCEPT) && r_key[4] && (r_key[1:0] != 2'd3)) begin
                r_opcode <= r_key[1:0];
            end
        end
    end

    assign bus.col_n   = r_col_n;
    assign bus.newhex  = r_newhex;
    assign bus.hexcode = r_hexcode;
    assign bus.newop   = r_newop;
    assign bus.opcode  = r_opcode;
    assign bus.eq      = r_eq;
    assign bus.keydown = (r_state == S_HELD);
endmodule
